regfile_wb_arbiter: RTL

Shares the register file's single write port between the main pipeline writeback stage and a multi-cycle unit (multiplier/divider) result channel. Pipeline writes have fixed priority. Multi-cycle results are parked in a small FIFO and drained into idle write-port cycles. A starvation counter forces a pipeline bubble when needed, and pending-write flags feed the hazard unit. The block sits between the writeback stage, the multi-cycle unit and the regfile write port (we3/wa3/wd3).

---
 rtl/regfile_wb_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: the pipeline writeback has priority, and multi-cycle
// results are bypassed or parked in a FIFO that drains into idle write cycles.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_wd,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_wa,
  input  logic [31:0] mdu_wd,
  output logic        mdu_ready,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        pend1,
  output logic        pend2,
  output logic        pipe_stall,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] LIM  = SW'(STARVE_LIMIT);

  logic [4:0]    r_wa [DEPTH];
  logic [31:0]   r_wd [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_stall;

  logic          w_nonempty;
  logic          w_ready;
  logic          w_accept;
  logic          w_pop;
  logic          w_bypass;
  logic          w_push;
  logic [SW-1:0] w_starve_nxt;
  logic [PW-1:0] w_off;

  assign w_nonempty = (r_count != '0);
  assign w_ready    = rst && (r_count < FULL);
  assign w_accept   = mdu_valid && w_ready;
  assign mdu_ready  = w_ready;
  assign pipe_stall = r_stall;

  always_comb begin
    we3      = 1'b0;
    wa3      = '0;
    wd3      = '0;
    w_pop    = 1'b0;
    w_bypass = 1'b0;
    if (rst) begin
      if (pipe_we) begin
        we3 = 1'b1;
        wa3 = pipe_wa;
        wd3 = pipe_wd;
      end else if (w_nonempty) begin
        we3   = 1'b1;
        wa3   = r_wa[r_rd_ptr];
        wd3   = r_wd[r_rd_ptr];
        w_pop = 1'b1;
      end else if (w_accept && (mdu_wa != '0)) begin
        we3      = 1'b1;
        wa3      = mdu_wa;
        wd3      = mdu_wd;
        w_bypass = 1'b1;
      end
    end
  end

  assign w_push = w_accept && (mdu_wa != '0) && !w_bypass;

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    w_off = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      w_off = PW'(j) - r_rd_ptr;
      if (rst && (CW'(w_off) < r_count)) begin
        if ((ra1 != '0) && (r_wa[j] == ra1)) pend1 = 1'b1;
        if ((ra2 != '0) && (r_wa[j] == ra2)) pend2 = 1'b1;
      end
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop)
      w_starve_nxt = '0;
    else if (w_nonempty && pipe_we && (r_starve != LIM))
      w_starve_nxt = r_starve + SW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
      r_starve <= w_starve_nxt;
      r_stall  <= w_pop ? 1'b0 : (r_stall || (w_starve_nxt == LIM));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wa[r_wr_ptr] <= mdu_wa;
      r_wd[r_wr_ptr] <= mdu_wd;
    end
  end

endmodule
